// File: rtl/dff_write_arbiter_if.sv
// dff_write_arbiter_if: request/write bus between four requesters and the shared register arbiter
//   req[3:0]        level request per requester, held until its ack
//   wdata[4*W-1:0]  requester i drives slice [i*W +: W]
//   grant[3:0]      one-hot current owner, zero when idle
//   ack[3:0]        one-cycle completion pulse to the owner
//   q, qbar         shared register and its complement
//   busy            arbiter is not idle
//   last_owner      index of the most recently acked requester
//   q_valid         sticky, set once any write has completed
interface dff_write_arbiter_if #(parameter int WIDTH = 8);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         grant;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qbar;
  logic               busy;
  logic [1:0]         last_owner;
  logic               q_valid;
  modport master (output req, wdata, input grant, ack, q, qbar, busy, last_owner, q_valid);
  modport slave  (input req, wdata, output grant, ack, q, qbar, busy, last_owner, q_valid);
endinterface

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter granting four requesters write access to one shared register
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      dff_write_arbiter_if slave: req/wdata in; grant/ack/q/qbar/busy/last_owner/q_valid out
module dff_write_arbiter #(
  parameter int WIDTH = 8
) (
  input logic                clock,
  input logic                reset_n,
  dff_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, win_q, win_d, last_q, last_d, pick;
  logic [3:0]       grant_q, grant_d, ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  // first set request at or after ptr, wrapping modulo 4; descending scan so the nearest wins
  always_comb begin
    pick = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (bus.req[ptr_q + 2'(k)]) pick = ptr_q + 2'(k);
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    q_d     = q_q;
    valid_d = valid_q;
    if (state_q == IDLE && |bus.req) begin
      win_d   = pick;
      grant_d = 4'b1 << pick;
      state_d = GRANT;
    end else if (state_q == GRANT) begin
      q_d     = bus.wdata[win_q*WIDTH +: WIDTH];
      ack_d   = grant_q;
      state_d = ACK;
    end else if (state_q == ACK) begin
      ack_d   = '0;
      grant_d = '0;
      ptr_d   = win_q + 2'd1;
      last_d  = win_q;
      valid_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      last_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end
  assign bus.grant      = grant_q;
  assign bus.ack        = ack_q;
  assign bus.q          = q_q;
  assign bus.qbar       = ~q_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.last_owner = last_q;
  assign bus.q_valid    = valid_q;
endmodule
